// File: rtl/regfile_pkg.sv
// Shared register-file types: data/index widths, the x0 index and the write-entry layout.
// Other RegisterFile32 users import these types as well.
package regfile_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } writeEntry_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO. The head entry is always visible on rdata.
// A push while full and a pop while empty are both ignored.
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     r,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign full   = (count == (PW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign rdata  = mem[rdPtr];

    // DEPTH is a power of two, so the pointers wrap by overflowing naturally.
    always_ff @(posedge clk) begin
        if (r) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            count <= count + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
        end
    end

    always_ff @(posedge clk) begin
        if (!r && doPush) mem[wrPtr] <= wdata;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges the ALU writeback and the buffered load results onto the single register-file write port.
// The ALU has priority, loads drain in acceptance order, and x0 writes are dropped.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic                  aluValid,
    input  logic [ADDR_WIDTH-1:0] aluRd,
    input  logic [DATA_WIDTH-1:0] aluData,
    input  logic                  ldValid,
    output logic                  ldReady,
    input  logic [ADDR_WIDTH-1:0] ldRd,
    input  logic [DATA_WIDTH-1:0] ldData,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] dataIn,
    output logic                  writeEn,
    output logic                  pending
);
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    logic [ENTRY_W-1:0]    fifoHead;
    logic [CW-1:0]         fifoCount;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  ldPush;
    logic                  aluWrite;
    logic                  headWrite;
    logic [ADDR_WIDTH-1:0] headRd;
    logic [DATA_WIDTH-1:0] headData;

    // Load handshake: a transfer happens at an edge where ldValid && ldReady.
    // ldReady depends only on reset and FIFO occupancy, never on ldValid.
    assign ldReady   = !r && !fifoFull;
    assign ldPush    = ldValid && ldReady && (ldRd != ADDR_WIDTH'(REG_ZERO));
    assign aluWrite  = aluValid && (aluRd != ADDR_WIDTH'(REG_ZERO));
    assign headWrite = !aluWrite && !fifoEmpty;
    assign headRd    = fifoHead[ENTRY_W-1 -: ADDR_WIDTH];
    assign headData  = fifoHead[DATA_WIDTH-1:0];
    assign pending   = (fifoCount != '0);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_loadFifo (
        .clk   (clk),
        .r     (r),
        .push  (ldPush),
        .pop   (headWrite),
        .wdata ({ldRd, ldData}),
        .rdata (fifoHead),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // rd/dataIn keep their last written values on idle cycles.
    always_ff @(posedge clk) begin
        if (r) begin
            writeEn <= 1'b0;
            rd      <= '0;
            dataIn  <= '0;
        end else begin
            writeEn <= aluWrite || headWrite;
            if (aluWrite) begin
                rd     <= aluRd;
                dataIn <= aluData;
            end else if (headWrite) begin
                rd     <= headRd;
                dataIn <= headData;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of the load buffer and write port.
module tb_regfile_write_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          r;
    logic          aluValid;
    logic [AW-1:0] aluRd;
    logic [DW-1:0] aluData;
    logic          ldValid;
    logic          ldReady;
    logic [AW-1:0] ldRd;
    logic [DW-1:0] ldData;
    logic [AW-1:0] rd;
    logic [DW-1:0] dataIn;
    logic          writeEn;
    logic          pending;

    regfile_write_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .r        (r),
        .aluValid (aluValid),
        .aluRd    (aluRd),
        .aluData  (aluData),
        .ldValid  (ldValid),
        .ldReady  (ldReady),
        .ldRd     (ldRd),
        .ldData   (ldData),
        .rd       (rd),
        .dataIn   (dataIn),
        .writeEn  (writeEn),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Model: pending loads in acceptance order, plus the expected write-port contents.
    logic [AW+DW-1:0] expQ[$];
    logic             expWe   = 1'b0;
    logic [AW-1:0]    expRd   = '0;
    logic [DW-1:0]    expData = '0;
    logic             lastAccept;
    logic [AW-1:0]    dutLog[$];

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic             acc;
        logic [AW+DW-1:0] e;
        acc = !r && ldValid && (expQ.size() < DEPTH);
        lastAccept = acc;
        @(posedge clk);
        #1;
        if (r) begin
            expQ.delete();
            expWe   = 1'b0;
            expRd   = '0;
            expData = '0;
        end else begin
            if (aluValid && aluRd != 0) begin
                expWe   = 1'b1;
                expRd   = aluRd;
                expData = aluData;
            end else if (expQ.size() > 0) begin
                e       = expQ.pop_front();
                expWe   = 1'b1;
                expRd   = e[AW+DW-1:DW];
                expData = e[DW-1:0];
            end else begin
                expWe = 1'b0;
            end
            if (acc && ldRd != 0) expQ.push_back({ldRd, ldData});
        end
        if (writeEn === 1'b1) dutLog.push_back(rd);
        checkEq("writeEn", 64'(writeEn), 64'(expWe));
        checkEq("rd", 64'(rd), 64'(expRd));
        checkEq("dataIn", 64'(dataIn), 64'(expData));
        checkEq("ldReady", 64'(ldReady), 64'(!r && expQ.size() < DEPTH));
        checkEq("pending", 64'(pending), 64'(expQ.size() != 0));
    endtask

    task automatic idleInputs();
        aluValid = 1'b0;
        aluRd    = '0;
        aluData  = '0;
        ldValid  = 1'b0;
        ldRd     = '0;
        ldData   = '0;
    endtask

    initial begin
        int k;
        int mark;
        int hits;
        idleInputs();

        // Reset with a live ALU request.
        r = 1'b1;
        aluValid = 1'b1;
        aluRd    = 5'd1;
        aluData  = 32'hdeadbeef;
        repeat (2) cycle();
        checkEq("t1_we", 64'(writeEn), 64'd0);
        checkEq("t1_rd", 64'(rd), 64'd0);
        checkEq("t1_data", 64'(dataIn), 64'd0);
        checkEq("t1_ready", 64'(ldReady), 64'd0);
        r = 1'b0;
        idleInputs();
        #1;
        checkEq("t1_ready_after", 64'(ldReady), 64'd1);
        checkEq("t1_pending_after", 64'(pending), 64'd0);
        cycle();

        // Single ALU write.
        aluValid = 1'b1;
        aluRd    = 5'd1;
        aluData  = 32'h28111172;
        cycle();
        aluValid = 1'b0;
        checkEq("t2_we", 64'(writeEn), 64'd1);
        checkEq("t2_rd", 64'(rd), 64'd1);
        checkEq("t2_data", 64'(dataIn), 64'h28111172);
        cycle();
        checkEq("t2_we_drop", 64'(writeEn), 64'd0);

        // Single load into an empty buffer.
        ldValid = 1'b1;
        ldRd    = 5'd2;
        ldData  = 32'h22857572;
        cycle();
        ldValid = 1'b0;
        checkEq("t3_pending_n", 64'(pending), 64'd1);
        checkEq("t3_we_n", 64'(writeEn), 64'd0);
        cycle();
        checkEq("t3_we", 64'(writeEn), 64'd1);
        checkEq("t3_rd", 64'(rd), 64'd2);
        checkEq("t3_data", 64'(dataIn), 64'h22857572);
        checkEq("t3_pending", 64'(pending), 64'd0);
        cycle();

        // ALU contention fills the buffer; loads drain once the ALU goes quiet.
        dutLog.delete();
        k = 0;
        for (int i = 0; i < 16; i++) begin
            aluValid = (i < 8);
            aluRd    = AW'(3 + i);
            aluData  = $urandom;
            ldValid  = (k < 5);
            ldRd     = AW'(11 + k);
            ldData   = $urandom;
            cycle();
            if (lastAccept) k++;
            if (i == 5) begin
                checkEq("t4_accepted", 64'(k), 64'd4);
                checkEq("t4_full_ready", 64'(ldReady), 64'd0);
            end
        end
        idleInputs();
        checkEq("t4_log_size", 64'(dutLog.size()), 64'd13);
        for (int i = 0; i < 13 && i < dutLog.size(); i++)
            checkEq("t4_order", 64'(dutLog[i]), 64'(i < 8 ? 3 + i : 11 + i - 8));

        // x0 destinations are dropped on both sides.
        dutLog.delete();
        aluValid = 1'b1;
        aluRd    = 5'd0;
        aluData  = 32'h12345678;
        cycle();
        idleInputs();
        ldValid = 1'b1;
        ldRd    = 5'd0;
        ldData  = 32'h87654321;
        checkEq("t5_ready", 64'(ldReady), 64'd1);
        cycle();
        checkEq("t5_accept", 64'(lastAccept), 64'd1);
        checkEq("t5_pending", 64'(pending), 64'd0);
        idleInputs();
        cycle();
        checkEq("t5_no_writes", 64'(dutLog.size()), 64'd0);

        // Reset while loads are stalled behind the ALU.
        for (int i = 0; i < 3; i++) begin
            aluValid = 1'b1;
            aluRd    = AW'(20 + i);
            aluData  = $urandom;
            ldValid  = 1'b1;
            ldRd     = AW'(4 + i);
            ldData   = $urandom;
            cycle();
        end
        ldValid = 1'b0;
        cycle();
        checkEq("t6_pending_before", 64'(pending), 64'd1);
        r = 1'b1;
        cycle();
        r = 1'b0;
        idleInputs();
        mark = dutLog.size();
        checkEq("t6_pending_after", 64'(pending), 64'd0);
        repeat (6) cycle();
        hits = 0;
        for (int i = mark; i < dutLog.size(); i++)
            if (dutLog[i] inside {5'd4, 5'd5, 5'd6}) hits++;
        checkEq("t6_lost_loads", 64'(hits), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            r        = ($urandom_range(0, 59) == 0);
            aluValid = ($urandom_range(0, 99) < 45);
            aluRd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            aluData  = $urandom;
            ldValid  = ($urandom_range(0, 99) < 60);
            ldRd     = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            ldData   = $urandom;
            cycle();
        end
        r = 1'b0;
        idleInputs();
        repeat (DEPTH + 2) cycle();
        checkEq("final_drain", 64'(pending), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
